// File: rtl/audio_mix_ring_pkg.sv
// Shared audio types and helpers for the sample mixer and its sources.
package audio_pkg;

  // Native sample width shared by the DMA stream, player and mixer.
  localparam int SAMPLE_W = 16;

  // Saturation bounds, held wide so any accumulator width up to 32 bits
  // can be compared without truncation.
  localparam logic signed [31:0] SAMPLE_MAX = (32'sd1 <<< (SAMPLE_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAMPLE_MIN = -(32'sd1 <<< (SAMPLE_W - 1));

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT,
    WRITE
  } mix_state_e;

  // Clamp a sign-extended accumulator into the sample range.
  function automatic sample_t sat_to_sample(input logic signed [31:0] acc);
    if (acc > SAMPLE_MAX) begin
      return sample_t'(SAMPLE_MAX);
    end else if (acc < SAMPLE_MIN) begin
      return sample_t'(SAMPLE_MIN);
    end
    return sample_t'(acc);
  endfunction

  // True when sat_to_sample would change the value.
  function automatic logic sat_clips(input logic signed [31:0] acc);
    return (acc > SAMPLE_MAX) || (acc < SAMPLE_MIN);
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Flop-based sample ring: one synchronous write port, one registered read
// port, whole array cleared by reset. A read of the slot being written in
// the same cycle returns the previous contents.
module sample_ring_buffer #(
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 mclk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Storage update and registered read of the addressed slot.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_mix_ring.sv
// Per-sample source mixer with saturation, writing LAG slots behind the
// serializer's read index into a playback ring.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for an index change or a pending event
//   ACCUM | adding one scaled source per cycle into acc
//   SAT   | clamping acc to the sample range, noting whether it clipped
//   WRITE | storing the clamped sample into its ring slot, clip pulses
//
// SAMPLE_BITS must equal audio_pkg::SAMPLE_W; the clamp helper is shared
// with the other sample producers at that width.
module audio_mix_ring
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_W,
  parameter int NUM_SOURCES = 2,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 32,
  parameter int LAG         = 10
) (
  input  logic                                    mclk,
  input  logic                                    rstn,
  input  logic [NUM_SOURCES-1:0][SAMPLE_BITS-1:0] src_sample,
  input  logic [NUM_SOURCES-1:0][VOLUME_BITS-1:0] src_volume,
  input  logic [NUM_SOURCES-1:0]                  src_valid,
  input  logic [$clog2(BUF_LEN)-1:0]              rd_index,
  output logic signed [SAMPLE_BITS-1:0]           rd_sample,
  output logic                                    busy,
  output logic                                    clip,
  output logic                                    overrun
);

  localparam int IDX_BITS  = $clog2(BUF_LEN);
  localparam int ACC_BITS  = SAMPLE_BITS + $clog2(NUM_SOURCES) + 1;
  localparam int K_BITS    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;

  mix_state_e state;
  logic [IDX_BITS-1:0] idx_q;
  logic [K_BITS-1:0]   k;
  logic signed [ACC_BITS-1:0] acc;
  sample_t sat_q;
  logic    clip_d;

  logic [NUM_SOURCES-1:0][SAMPLE_BITS-1:0] cur_sample, pend_sample;
  logic [NUM_SOURCES-1:0][VOLUME_BITS-1:0] cur_volume, pend_volume;
  logic [NUM_SOURCES-1:0]                  cur_valid, pend_valid;
  logic [IDX_BITS-1:0]                     cur_slot, pend_slot;
  logic                                    pend_full;

  logic                        idx_event;
  logic [IDX_BITS-1:0]         event_slot;
  logic                        take_pend;
  logic signed [SAMPLE_BITS-1:0] cur_s;
  logic [VOLUME_BITS-1:0]        cur_v;
  logic signed [PROD_BITS-1:0]   prod;
  logic signed [ACC_BITS-1:0]    scaled;
  logic [SAMPLE_BITS-1:0]        ring_rd;

  assign idx_event  = (rd_index != idx_q);
  assign event_slot = rd_index - IDX_BITS'(LAG);
  // The pending slot is vacated in the same cycle it is handed to the mixer.
  assign take_pend  = pend_full && (state == IDLE || state == WRITE);

  // Scale the source currently selected by k; full-scale volume is exact unity.
  always_comb begin
    cur_s  = cur_sample[k];
    cur_v  = cur_volume[k];
    prod   = cur_s * $signed({1'b0, cur_v});
    scaled = '0;
    if (cur_valid[k]) begin
      if (&cur_v) begin
        scaled = ACC_BITS'(cur_s);
      end else begin
        scaled = ACC_BITS'(prod >>> VOLUME_BITS);
      end
    end
  end

  // Mixer sequencing, event capture, pending slot and status outputs.
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      idx_q       <= '0;
      k           <= '0;
      acc         <= '0;
      sat_q       <= '0;
      clip_d      <= 1'b0;
      cur_sample  <= '0;
      cur_volume  <= '0;
      cur_valid   <= '0;
      cur_slot    <= '0;
      pend_sample <= '0;
      pend_volume <= '0;
      pend_valid  <= '0;
      pend_slot   <= '0;
      pend_full   <= 1'b0;
      busy        <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      idx_q <= rd_index;
      clip  <= 1'b0;

      // Events that cannot start a mix right now go to the pending slot.
      if (idx_event && (state != IDLE || pend_full)) begin
        if (!pend_full || take_pend) begin
          pend_full   <= 1'b1;
          pend_sample <= src_sample;
          pend_volume <= src_volume;
          pend_valid  <= src_valid;
          pend_slot   <= event_slot;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pend_full) begin
            cur_sample <= pend_sample;
            cur_volume <= pend_volume;
            cur_valid  <= pend_valid;
            cur_slot   <= pend_slot;
            if (!idx_event) pend_full <= 1'b0;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end else if (idx_event) begin
            cur_sample <= src_sample;
            cur_volume <= src_volume;
            cur_valid  <= src_valid;
            cur_slot   <= event_slot;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + scaled;
          k   <= k + K_BITS'(1);
          if (k == K_BITS'(NUM_SOURCES - 1)) begin
            state <= SAT;
          end
        end
        SAT: begin
          sat_q  <= sat_to_sample(32'(acc));
          clip_d <= sat_clips(32'(acc));
          clip   <= sat_clips(32'(acc));
          state  <= WRITE;
        end
        WRITE: begin
          if (pend_full) begin
            cur_sample <= pend_sample;
            cur_volume <= pend_volume;
            cur_valid  <= pend_valid;
            cur_slot   <= pend_slot;
            if (!idx_event) pend_full <= 1'b0;
            acc   <= '0;
            k     <= '0;
            state <= ACCUM;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  sample_ring_buffer #(
    .DATA_BITS (SAMPLE_BITS),
    .DEPTH     (BUF_LEN),
    .ADDR_BITS (IDX_BITS)
  ) u_ring (
    .mclk    (mclk),
    .rstn    (rstn),
    .wr_en   (state == WRITE),
    .wr_addr (cur_slot),
    .wr_data (sat_q),
    .rd_addr (rd_index),
    .rd_data (ring_rd)
  );

  assign rd_sample = ring_rd;

endmodule

// File: tb/tb_audio_mix_ring.sv
module tb_audio_mix_ring;

  logic              mclk;
  logic              rstn;
  logic [1:0][15:0]  src_sample;
  logic [1:0][7:0]   src_volume;
  logic [1:0]        src_valid;
  logic [4:0]        rd_index;
  logic signed [15:0] rd_sample;
  logic              busy;
  logic              clip;
  logic              overrun;

  int tests;
  int fails;

  audio_mix_ring dut (
    .mclk       (mclk),
    .rstn       (rstn),
    .src_sample (src_sample),
    .src_volume (src_volume),
    .src_valid  (src_valid),
    .rd_index   (rd_index),
    .rd_sample  (rd_sample),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int s0, input int s1, input int v0, input int v1,
                         input logic [1:0] valid);
    src_sample[0] = 16'(s0);
    src_sample[1] = 16'(s1);
    src_volume[0] = 8'(v0);
    src_volume[1] = 8'(v1);
    src_valid     = valid;
  endtask

  // Trigger a mix targeting slot idx-10 and let it finish.
  task automatic mix(input int idx);
    rd_index = 5'(idx);
    repeat (6) tick();
  endtask

  // Trigger a mix and check the clip pulse lands only in the WRITE cycle.
  task automatic mix_clip(input string tag, input int idx, input logic exp_clip);
    rd_index = 5'(idx);
    repeat (3) tick();
    chk({tag, "_clip_sat"}, clip, 0);
    tick();
    chk({tag, "_clip_write"}, clip, exp_clip);
    chk({tag, "_busy_write"}, busy, 1);
    tick();
    chk({tag, "_clip_after"}, clip, 0);
    chk({tag, "_busy_after"}, busy, 0);
    tick();
  endtask

  // Read a slot; sources are invalidated so the side-effect mix writes zero.
  task automatic rd(input string tag, input int idx, input int exp);
    src_valid = 2'b00;
    rd_index  = 5'(idx);
    tick();
    chk(tag, rd_sample, exp);
    repeat (6) tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Reset with busy-looking inputs
    rstn = 1'b0;
    set_src(1234, -77, 200, 255, 2'b11);
    rd_index = 5'd7;
    repeat (3) tick();
    chk("rst_rd_sample", rd_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    rd_index = 5'd0;
    tick();
    rstn = 1'b1;
    tick();
    chk("rel_busy", busy, 0);

    // Sweep every slot: all zero after reset
    set_src(0, 0, 0, 0, 2'b00);
    for (int i = 1; i < 32; i++) begin
      rd_index = 5'(i);
      tick();
      chk("sweep_zero", rd_sample, 0);
    end
    rstn = 1'b0;
    rd_index = 5'd0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("rerst_overrun", overrun, 0);

    // Unity mix into slot 23 with busy window
    set_src(1000, -200, 255, 255, 2'b11);
    rd_index = 5'd1;
    tick();
    chk("unity_busy_e1", busy, 1);
    tick();
    chk("unity_busy_e2", busy, 1);
    tick();
    chk("unity_busy_e3", busy, 1);
    tick();
    chk("unity_busy_e4", busy, 1);
    chk("unity_clip_e4", clip, 0);
    tick();
    chk("unity_busy_e5", busy, 0);
    tick();
    rd("unity_slot23", 23, 800);

    // Volume scaling and source valid
    mix(5);
    set_src(16384, 5000, 128, 255, 2'b01);
    mix(6);
    set_src(-3, 5000, 128, 255, 2'b01);
    mix(7);
    rd("half_vol_slot28", 28, 8192);
    rd("neg_floor_slot29", 29, -2);

    // Saturation
    set_src(30000, 30000, 255, 255, 2'b11);
    mix_clip("sat_pos", 12, 1'b1);
    set_src(-30000, -30000, 255, 255, 2'b11);
    mix_clip("sat_neg", 13, 1'b1);
    set_src(100, 100, 255, 255, 2'b11);
    mix_clip("no_sat", 14, 1'b0);
    rd("sat_pos_slot2", 2, 32767);
    rd("sat_neg_slot3", 3, -32768);
    rd("no_sat_slot4", 4, 200);

    // Back-to-back events: mix, pend, drop
    set_src(100, 0, 255, 255, 2'b11);
    rd_index = 5'd20;
    tick();
    set_src(300, 0, 255, 255, 2'b11);
    rd_index = 5'd21;
    tick();
    chk("ovr_after_pend", overrun, 0);
    set_src(500, 0, 255, 255, 2'b11);
    rd_index = 5'd22;
    tick();
    chk("ovr_after_drop", overrun, 1);
    repeat (5) tick();
    chk("pend_busy_e8", busy, 1);
    tick();
    chk("pend_busy_e9", busy, 0);
    rd("first_slot10", 10, 100);
    rd("pend_slot11", 11, 300);
    rd("dropped_slot12", 12, 0);
    chk("ovr_sticky", overrun, 1);

    // Reset during ACCUM aborts without writing
    set_src(1000, 0, 255, 255, 2'b11);
    rd_index = 5'd25;
    tick();
    chk("midmix_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midmix_rst_busy", busy, 0);
    rd_index = 5'd0;
    tick();
    rstn = 1'b1;
    tick();
    chk("midmix_rel_busy", busy, 0);
    chk("midmix_rel_ovr", overrun, 0);
    rd("midmix_slot15", 15, 0);
    set_src(1234, 0, 255, 255, 2'b11);
    mix(16);
    rd("post_rst_slot6", 6, 1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
